// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared widths and FSM state encoding for the 4x4 shift-and-add multiplier.
package seq_mult_pkg;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_mult_dp.sv
// seq_mult_dp: A/ACC/Q registers and the single 4-bit ripple adder of the shift-and-add multiplier.
module seq_mult_dp
  import seq_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_add,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_q0,
  output logic [2*WIDTH-1:0]   o_shift
);
  logic [WIDTH-1:0] r_a, r_acc, r_q, w_addend, w_sum;
  logic [WIDTH:0]   w_c;
  assign w_addend = i_add ? r_a : '0;
  assign w_c[0]   = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]  = r_acc[i] ^ w_addend[i] ^ w_c[i];
    assign w_c[i+1]  = (r_acc[i] & w_addend[i]) | (w_c[i] & (r_acc[i] ^ w_addend[i]));
  end
  // {C,ACC,Q[3:1]} is exactly the post-shift {ACC,Q}; the carry lands in ACC[3] and C returns to 0
  assign o_shift = {w_c[WIDTH], w_sum, r_q[WIDTH-1:1]};
  assign o_q0    = r_q[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_acc <= '0;
      r_q   <= '0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_acc <= '0;
      r_q   <= i_b;
    end else if (i_step) begin
      {r_acc, r_q} <= o_shift;
    end
  end
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: FSM, iteration counter and start/busy/done handshake for a 4x4 sequential multiplier.
// Optional ZERO_SKIP_EN: a start with a zero operand jumps straight to DONE with product 0.
module seq_mult_ctrl
  import seq_mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  state_t               r_state, w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_load, w_step, w_last, w_zero, w_q0;
  logic [2*WIDTH-1:0]   w_shift;
`ifdef ZERO_SKIP_EN
  assign w_zero = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero = 1'b0;
`endif
  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = r_state == S_CALC;
  assign w_last = r_cnt == CNT_W'(WIDTH - 1);
  seq_mult_dp u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_add   (w_q0),
    .i_a     (multiplicand),
    .i_b     (multiplier),
    .o_q0    (w_q0),
    .o_shift (w_shift)
  );
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;
  // DONE and the unused encoding both fall back to IDLE
  always_comb begin
    w_next = (r_state == S_IDLE) ? (start ? (w_zero ? S_DONE : S_CALC) : S_IDLE) :
             (r_state == S_CALC) ? (w_last ? S_DONE : S_CALC) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    r_cnt   <= (rst || w_load) ? '0 : w_step ? r_cnt + 1'b1 : r_cnt;
    product <= rst ? '0 : (w_step && w_last) ? w_shift : (w_load && w_zero) ? '0 : product;
  end
  always_comb begin
    busy = r_state == S_CALC;
    done = r_state == S_DONE;
  end
endmodule
